// File: rtl/ser_loader.sv
// Serial boot loader: polls the serial interface for a load frame, packs the
// payload into big-endian words, writes them to memory and echoes a checksum.
module ser_loader #(
    parameter int POLL_GAP = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ser_stb,
    output logic        o_ser_we,
    output logic [1:0]  o_ser_addr,
    output logic [7:0]  o_ser_dout,
    input  logic [7:0]  i_ser_din,
    input  logic        i_ser_ack,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_dout,
    input  logic        i_mem_ack
);
    localparam int GW = $clog2(POLL_GAP + 2);
    localparam logic [GW-1:0] GAP_MIN  = GW'(1);
    localparam logic [GW-1:0] GAP_POLL = GW'(POLL_GAP + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_POLL, S_HDR_READ, S_DAT_POLL, S_DAT_READ,
        S_MEM_WR, S_XMT_POLL, S_XMT_WR, S_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [GW-1:0] r_gap;
    logic [2:0]    r_hdr_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_count;
    logic [31:0]   r_word;
    logic [1:0]    r_byte_idx;
    logic [7:0]    r_csum;

    logic          w_active;
    logic          w_ser_ack;
    logic          w_mem_ack;
    logic          w_rdy;
    logic [31:0]   w_count_hdr;

    assign w_active    = (r_gap == '0);
    assign w_ser_ack   = o_ser_stb & i_ser_ack;
    assign w_mem_ack   = o_mem_stb & i_mem_ack;
    assign w_rdy       = i_ser_din[0];
    assign w_count_hdr = {r_count[23:0], i_ser_din};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_state_next = S_HDR_POLL;
            S_HDR_POLL: if (w_ser_ack && w_rdy) w_state_next = S_HDR_READ;
            S_HDR_READ: if (w_ser_ack) begin
                if (r_hdr_cnt != 3'd7)       w_state_next = S_HDR_POLL;
                else if (w_count_hdr == '0)  w_state_next = S_XMT_POLL;
                else                         w_state_next = S_DAT_POLL;
            end
            S_DAT_POLL: if (w_ser_ack && w_rdy) w_state_next = S_DAT_READ;
            S_DAT_READ: if (w_ser_ack)
                w_state_next = (r_byte_idx == 2'd3 || r_count == 32'd1) ? S_MEM_WR : S_DAT_POLL;
            S_MEM_WR:   if (w_mem_ack)
                w_state_next = (r_count != '0) ? S_DAT_POLL : S_XMT_POLL;
            S_XMT_POLL: if (w_ser_ack && w_rdy) w_state_next = S_XMT_WR;
            S_XMT_WR:   if (w_ser_ack) w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Strobes are held low while r_gap counts down, giving the mandatory idle
    // cycle after every access plus the extra polling back-off.
    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_ser_stb  = 1'b0;
        o_ser_we   = 1'b0;
        o_ser_addr = 2'b00;
        o_ser_dout = 8'h00;
        o_mem_stb  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_dout = '0;
        case (r_state)
            S_HDR_POLL, S_DAT_POLL: begin
                o_busy    = 1'b1;
                o_ser_stb = w_active;
            end
            S_HDR_READ, S_DAT_READ: begin
                o_busy     = 1'b1;
                o_ser_stb  = w_active;
                o_ser_addr = 2'b01;
            end
            S_XMT_POLL: begin
                o_busy     = 1'b1;
                o_ser_stb  = w_active;
                o_ser_addr = 2'b10;
            end
            S_XMT_WR: begin
                o_busy     = 1'b1;
                o_ser_stb  = w_active;
                o_ser_we   = 1'b1;
                o_ser_addr = 2'b11;
                o_ser_dout = r_csum;
            end
            S_MEM_WR: begin
                o_busy     = 1'b1;
                o_mem_stb  = w_active;
                o_mem_we   = w_active;
                o_mem_addr = r_addr[31:2];
                o_mem_dout = r_word;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap      <= '0;
            r_hdr_cnt  <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
        end else begin
            if (r_gap != '0) r_gap <= r_gap - GAP_MIN;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_gap      <= '0;
                    r_hdr_cnt  <= '0;
                    r_word     <= '0;
                    r_byte_idx <= '0;
                    r_csum     <= '0;
                end
                S_HDR_POLL, S_DAT_POLL, S_XMT_POLL:
                    if (w_ser_ack) r_gap <= w_rdy ? GAP_MIN : GAP_POLL;
                S_HDR_READ: if (w_ser_ack) begin
                    r_gap     <= GAP_MIN;
                    r_hdr_cnt <= r_hdr_cnt + 3'd1;
                    if (r_hdr_cnt[2]) r_count <= w_count_hdr;
                    else              r_addr  <= {r_addr[23:0], i_ser_din};
                end
                S_DAT_READ: if (w_ser_ack) begin
                    r_gap      <= GAP_MIN;
                    r_word     <= r_word | ({i_ser_din, 24'h000000} >> {r_byte_idx, 3'b000});
                    r_csum     <= r_csum + i_ser_din;
                    r_count    <= r_count - 32'd1;
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
                S_MEM_WR: if (w_mem_ack) begin
                    r_gap        <= GAP_MIN;
                    r_addr[31:2] <= r_addr[31:2] + 30'd1;
                    r_word       <= '0;
                    r_byte_idx   <= '0;
                end
                S_XMT_WR: if (w_ser_ack) r_gap <= GAP_MIN;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ser_loader.sv
// Bench for ser_loader: serial/memory responders plus a frame-level model of
// the words and checksum a load must produce.
module tb_ser_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        o_busy, o_done, o_ser_stb, o_ser_we, o_mem_stb, o_mem_we;
    logic [1:0]  o_ser_addr;
    logic [7:0]  o_ser_dout;
    logic [29:0] o_mem_addr;
    logic [31:0] o_mem_dout;
    logic [7:0]  ser_din = 8'h00;
    logic        ser_ack = 1'b0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    ser_loader #(.POLL_GAP(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(o_busy), .o_done(o_done),
        .o_ser_stb(o_ser_stb), .o_ser_we(o_ser_we), .o_ser_addr(o_ser_addr),
        .o_ser_dout(o_ser_dout), .i_ser_din(ser_din), .i_ser_ack(ser_ack),
        .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_dout(o_mem_dout), .i_mem_ack(mem_ack)
    );

    int n_vec = 0;
    int n_err = 0;

    // Slave configuration and bookkeeping
    int rcv_hold = 0, xmt_hold = 0, mem_delay = 0, ser_delay = 0;
    int rcv_wait = 0, xmt_wait = 0;
    bit rcv_ready = 0, xmt_ready = 0;
    int n_poll0 = 0, n_rd01 = 0, n_xmt_wr = 0, done_cnt = 0;
    logic [7:0]  csum_got = 8'h00;
    logic [7:0]  rcv_q[$];
    logic [7:0]  dat[$];
    logic [29:0] got_a[$];
    logic [31:0] got_d[$];
    logic [29:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [7:0]  exp_csum = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] ga(input int i);
        return (i < got_a.size()) ? got_a[i] : 30'h2AAAAAAA;
    endfunction

    function automatic logic [31:0] gd(input int i);
        return (i < got_d.size()) ? got_d[i] : 32'hDEADBEEF;
    endfunction

    task automatic ser_access(input logic [1:0] a, input logic w, input logic [7:0] d);
        if (w) begin
            check("ser_write_addr", a, 2'b11);
            if (a == 2'b11) begin
                check("xmt_ready_before_write", xmt_ready, 1);
                csum_got = d;
                n_xmt_wr++;
            end
        end else begin
            case (a)
                2'b00: begin
                    n_poll0++;
                    if (rcv_q.size() > 0 && rcv_wait >= rcv_hold) begin
                        ser_din = 8'h01; rcv_ready = 1;
                    end else begin
                        ser_din = 8'h00; rcv_wait++;
                    end
                end
                2'b01: begin
                    check("rcv_read_after_ready", rcv_ready, 1);
                    n_rd01++;
                    rcv_ready = 0;
                    rcv_wait  = 0;
                    ser_din   = (rcv_q.size() > 0) ? rcv_q.pop_front() : 8'h00;
                end
                2'b10: begin
                    if (xmt_wait >= xmt_hold) begin
                        ser_din = 8'h01; xmt_ready = 1;
                    end else begin
                        ser_din = 8'h00; xmt_wait++;
                    end
                end
                default: check("ser_read_addr", a, 2'b00);
            endcase
        end
    endtask

    // Serial slave: ack is driven at a falling edge, taken at the next rising edge.
    initial begin : ser_resp
        int wcnt;
        bit pend;
        logic [10:0] req;
        wcnt = 0; pend = 0; req = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ser_ack = 1'b0; pend = 0;
            end else if (ser_ack) begin
                ser_ack = 1'b0; pend = 0;
                check("ser_stb_gap", o_ser_stb, 0);
            end else if (o_ser_stb) begin
                if (!pend) begin
                    pend = 1; wcnt = 0;
                    req = {o_ser_addr, o_ser_we, o_ser_dout};
                end else begin
                    check("ser_req_stable", {o_ser_addr, o_ser_we, o_ser_dout}, req);
                end
                if (wcnt >= ser_delay) begin
                    ser_access(req[10:9], req[8], req[7:0]);
                    ser_ack = 1'b1;
                end else wcnt++;
            end
        end
    end

    initial begin : mem_resp
        int wcnt;
        bit pend;
        logic [61:0] req;
        wcnt = 0; pend = 0; req = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0; pend = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0; pend = 0;
                check("mem_stb_gap", o_mem_stb, 0);
            end else if (o_mem_stb) begin
                if (!pend) begin
                    pend = 1; wcnt = 0;
                    req = {o_mem_addr, o_mem_dout};
                end else begin
                    check("mem_req_stable", {o_mem_addr, o_mem_dout}, req);
                end
                if (wcnt >= mem_delay) begin
                    got_a.push_back(req[61:32]);
                    got_d.push_back(req[31:0]);
                    mem_ack = 1'b1;
                end else wcnt++;
            end
        end
    end

    // Per-cycle port rules
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n && (o_ser_stb || o_mem_stb)) begin
                check("port_overlap", o_ser_stb & o_mem_stb, 0);
                if (o_mem_stb) check("mem_we", o_mem_we, 1);
            end
            if (o_done) begin
                done_cnt++;
                check("busy_low_at_done", o_busy, 0);
            end
        end
    end

    task automatic setup_load(input logic [31:0] la, input int rh, input int xh, input int md, input int sd);
        logic [29:0] wa;
        logic [31:0] w;
        logic [31:0] nn;
        int n;
        n  = dat.size();
        nn = n;
        exp_a.delete(); exp_d.delete();
        wa = la[31:2];
        for (int i = 0; i < n; i += 4) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (i + k < n) w[31-8*k -: 8] = dat[i+k];
            exp_a.push_back(wa);
            exp_d.push_back(w);
            wa = wa + 30'd1;
        end
        exp_csum = 8'h00;
        foreach (dat[i]) exp_csum = exp_csum + dat[i];
        rcv_q.delete();
        for (int b = 3; b >= 0; b--) rcv_q.push_back(la[8*b +: 8]);
        for (int b = 3; b >= 0; b--) rcv_q.push_back(nn[8*b +: 8]);
        foreach (dat[i]) rcv_q.push_back(dat[i]);
        rcv_hold = rh; xmt_hold = xh; mem_delay = md; ser_delay = sd;
        rcv_wait = 0; xmt_wait = 0; rcv_ready = 0; xmt_ready = 0;
        n_poll0 = 0; n_rd01 = 0; n_xmt_wr = 0; done_cnt = 0; csum_got = 8'h00;
        got_a.delete(); got_d.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", o_busy, 1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic finish_load(input int rh);
        int cyc;
        int n;
        n = dat.size();
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge clk); cyc++;
        end
        check("done_within_budget", (done_cnt > 0), 1);
        repeat (3) @(negedge clk);
        check("done_pulse_count", done_cnt, 1);
        check("busy_after_done", o_busy, 0);
        check("mem_write_count", got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            check("mem_addr", ga(i), exp_a[i]);
            check("mem_data", gd(i), exp_d[i]);
        end
        check("xmt_write_count", n_xmt_wr, 1);
        check("checksum", csum_got, exp_csum);
        check("rcv_data_reads", n_rd01, 8 + n);
        check("rcv_polls", n_poll0, (8 + n) * (rh + 1));
        check("bytes_left", rcv_q.size(), 0);
    endtask

    task automatic run_load(input logic [31:0] la, input int rh, input int xh, input int md, input int sd);
        setup_load(la, rh, xh, md, sd);
        finish_load(rh);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ser_outputs"}, {o_busy, o_done, o_ser_stb, o_ser_we, o_ser_addr, o_ser_dout}, 0);
        check({tag, "_mem_outputs"}, {o_mem_stb, o_mem_we, o_mem_addr, o_mem_dout}, 0);
    endtask

    initial begin : main
        int cyc;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        dat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(32'h00001000, 0, 0, 0, 0);
        check("t1_addr0", ga(0), 30'h400);
        check("t1_data0", gd(0), 32'h01020304);
        check("t1_addr1", ga(1), 30'h401);
        check("t1_data1", gd(1), 32'h05060708);
        check("t1_csum", csum_got, 8'h24);

        dat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load(32'h00002003, 0, 0, 0, 0);
        check("t2_addr0", ga(0), 30'h800);
        check("t2_data0", gd(0), 32'hAABBCCDD);
        check("t2_data1", gd(1), 32'hEE000000);
        check("t2_csum", csum_got, 8'hFC);

        dat.delete();
        run_load(32'h00004000, 0, 4, 0, 0);
        check("t3_no_mem_writes", got_a.size(), 0);
        check("t3_csum", csum_got, 8'h00);

        dat = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        run_load(32'h00000100, 20, 0, 0, 0);

        dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        run_load(32'h00000200, 0, 10, 3, 1);
        check("t5_data1", gd(1), 32'h55667700);

        dat = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};
        run_load(32'hFFFFFFFC, 0, 0, 0, 0);
        check("t6_wrap_addr0", ga(0), 30'h3FFFFFFF);
        check("t6_wrap_addr1", ga(1), 30'h00000000);

        dat = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        setup_load(32'h00003000, 0, 0, 0, 0);
        cyc = 0;
        while (n_rd01 < 10 && cyc < 2000) begin
            @(negedge clk); cyc++;
        end
        check("t7_reached_third_byte", (n_rd01 >= 10), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midload_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        dat = '{8'h0F, 8'h1E, 8'h2D};
        run_load(32'h00000040, 0, 0, 0, 0);
        check("t7_addr0", ga(0), 30'h010);
        check("t7_data0", gd(0), 32'h0F1E2D00);
        check("t7_csum", csum_got, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ser_loader.md
Name: ser_loader

Overview:
- Hardware serial boot loader. Acts as bus initiator on the serial line interface register port: polls the receive status, reads bytes, and packs them into 32-bit big-endian words.
- Writes the words to memory through a separate word-wide write master port.
- When the load completes, returns an 8-bit checksum to the host through the serial transmit data register.
- Sits between the serial interface's internal bus port and the memory arbiter; active only after a start pulse.

Parameters:
- POLL_GAP, 0: idle cycles inserted between consecutive status polls (0 = back-to-back polling).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; begins a load when idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the checksum byte is written
- ser_stb  out  1  serial register access strobe
- ser_we  out  1  1 = write, 0 = read
- ser_addr  out  2  register select (bits 3:2): 00 rcv ctrl, 01 rcv data, 10 xmt ctrl, 11 xmt data
- ser_dout  out  8  write data to serial interface
- ser_din  in  8  read data from serial interface
- ser_ack  in  1  access complete
- mem_stb  out  1  memory write strobe
- mem_we  out  1  always 1 while mem_stb is high
- mem_addr  out  30  word address (byte address bits 31:2)
- mem_dout  out  32  write data
- mem_ack  in  1  memory write complete

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs are 0: busy, done, ser_stb, ser_we, ser_addr, ser_dout, mem_stb, mem_we, mem_addr, mem_dout. Checksum and counters are cleared. A reset mid-load aborts immediately; memory already written stays written.
- Bus cycles (both ports):
  - The initiator holds stb and all address/data signals stable until it samples ack high on a rising edge.
  - On that edge it captures read data and drops stb for at least 1 cycle before the next access.
  - A rcv-data read (addr 01) consumes the received byte. It is issued exactly once per byte.
- Frame format from host: 4-byte load address (MSB first), then 4-byte byte count N (MSB first), then N data bytes. Load address bits 1:0 are ignored.
- States:
  - IDLE: start=1 moves to HDR_POLL and sets busy=1. A start pulse while busy is ignored.
  - HDR_POLL / DAT_POLL: read addr 00. If ser_din[0]=0, wait POLL_GAP cycles and repoll. If ser_din[0]=1, go to the matching READ state.
  - HDR_READ: read addr 01 and shift the byte into the address or count register. After 8 bytes: if N=0, go to XMT_POLL; otherwise go to DAT_POLL.
  - DAT_READ: read addr 01. Shift the byte into the word assembly register (first byte into bits 31:24), add it to the checksum mod 256, and decrement N. When 4 bytes are assembled or N reaches 0, go to MEM_WR; otherwise go to DAT_POLL.
  - MEM_WR: mem_stb=1 with mem_addr = current word address and mem_dout = assembled word. A partial last word has its unfilled low bytes set to 0x00. On mem_ack: word address +1 (wraps mod 2^30), clear the assembly register, then go to DAT_POLL if N>0, else XMT_POLL.
  - XMT_POLL: read addr 10. Repoll until ser_din[0]=1.
  - XMT_WR: write addr 11 with ser_dout = checksum. On ack go to DONE.
  - DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Never writes addr 00 or 10, so the serial interrupt enables are untouched.
- Memory writes never overlap serial accesses.
- Minimum latency per data byte: 4 cycles (poll, gap, read, gap) with immediate acks.

Test Plan:
- Header 00 00 10 00 / 00 00 00 08, data 01..08, all acks immediate -> mem writes word addr 0x400 <= 0x01020304 and 0x401 <= 0x05060708; ser write addr 11 data 0x24; done pulses once; busy low afterwards.
- N=5, data AA BB CC DD EE -> writes 0xAABBCCDD, then 0xEE000000; checksum byte 0xFC.
- N=0 -> mem_stb never asserted; checksum 0x00 written after xmt ctrl bit0=1.
- rcv ctrl bit0 held 0 for 20 polls, then 1 -> only addr 00 reads during the wait; exactly one addr 01 read per byte; no byte lost or duplicated.
- mem_ack delayed 3 cycles and xmt ctrl bit0 low for 10 polls -> mem_stb, mem_addr, mem_dout stable until ack; no addr 11 write before xmt ready.
- rst driven low during the 3rd data byte, then a fresh start with a new frame -> all outputs 0 asynchronously; the second load completes correctly from its own header.
